// File: rtl/pwl_coeff_loader_pkg.sv
// rtl/pwl_coeff_loader_pkg.sv - shared constants, header layout and state type for the PWL coefficient loader
package pwl_coeff_loader_pkg;

  // Opcode that starts a coefficient load frame
  localparam logic [3:0] PWL_LOAD_OPCODE = 4'h1;

  // Header word field positions (32-bit header)
  localparam int HDR_OPCODE_LSB  = 28;
  localparam int HDR_SETTING_LSB = 24;
  localparam int HDR_ADDR_LSB    = 12;
  localparam int HDR_COUNT_LSB   = 0;
  localparam int HDR_NIBBLE_W    = 4;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_OFF  = 3'd1,
    LD_SLP  = 3'd2,
    LD_BIAS = 3'd3,
    LD_CHK  = 3'd4
  } loader_state_e;

  // True when a header setting index addresses an existing table
  function automatic logic setting_in_range(input logic [HDR_NIBBLE_W-1:0] s, input int n);
    return int'({28'd0, s}) < n;
  endfunction

endpackage

// File: rtl/pwl_frame_checksum.sv
// rtl/pwl_frame_checksum.sv - running XOR over frame payload words with compare output
module pwl_frame_checksum #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [WORD_WIDTH-1:0] cmp_word,
  output logic                  match
);

  logic [WORD_WIDTH-1:0] sum_q;
  logic [WORD_WIDTH-1:0] sum_d;

  // Clear wins over accumulate so a header always starts a fresh sum
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (acc_en) begin
      sum_d = sum_q ^ word;
    end
  end

  // Running checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == cmp_word);

endmodule

// File: rtl/pwl_coeff_loader.sv
// rtl/pwl_coeff_loader.sv - frame decoder writing PWL segment and bias coefficient RAMs
module pwl_coeff_loader
  import pwl_coeff_loader_pkg::*;
#(
  parameter int N_SETTINGS    = 4,
  parameter int SETTING_WIDTH = 2,
  parameter int ADDR_WIDTH    = 8,
  parameter int OFFSET_WIDTH  = 18,
  parameter int SLOPE_WIDTH   = 18,
  parameter int BIAS_WIDTH    = 18,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [WORD_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                seg_we,
  output logic [SETTING_WIDTH+ADDR_WIDTH-1:0] seg_addr,
  output logic [OFFSET_WIDTH+SLOPE_WIDTH-1:0] seg_data,
  output logic                                bias_we,
  output logic [SETTING_WIDTH-1:0]            bias_addr,
  output logic [BIAS_WIDTH-1:0]               bias_data,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          err,
  input  logic                                err_clr
);

  localparam int REM_W = ADDR_WIDTH + 1;

  loader_state_e state_q, state_d;

  // Frame context
  logic [SETTING_WIDTH-1:0]            setting_q, setting_d;
  logic                                setting_ok_q, setting_ok_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
  logic [REM_W-1:0]                    rem_q, rem_d;
  logic [OFFSET_WIDTH-1:0]             offset_q, offset_d;
  logic [BIAS_WIDTH-1:0]               bias_q, bias_d;

  // Registered outputs
  logic                                in_ready_q, in_ready_d;
  logic                                seg_we_q, seg_we_d;
  logic [SETTING_WIDTH+ADDR_WIDTH-1:0] seg_addr_q, seg_addr_d;
  logic [OFFSET_WIDTH+SLOPE_WIDTH-1:0] seg_data_q, seg_data_d;
  logic                                bias_we_q, bias_we_d;
  logic [SETTING_WIDTH-1:0]            bias_addr_q, bias_addr_d;
  logic [BIAS_WIDTH-1:0]               bias_data_q, bias_data_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic [1:0]                          err_q, err_d;

  // Header decode and handshake
  logic                                fire;
  logic [HDR_NIBBLE_W-1:0]             hdr_opcode;
  logic [HDR_NIBBLE_W-1:0]             hdr_setting;
  logic [ADDR_WIDTH-1:0]               hdr_addr;
  logic [ADDR_WIDTH-1:0]               hdr_count_m1;
  logic                                hdr_is_load;
  logic                                hdr_setting_ok;

  // Checksum interface
  logic                                ck_clr;
  logic                                ck_acc;
  logic                                ck_match;
  logic [1:0]                          err_new;

  assign fire           = in_valid & in_ready_q;
  assign hdr_opcode     = in_data[HDR_OPCODE_LSB +: HDR_NIBBLE_W];
  assign hdr_setting    = in_data[HDR_SETTING_LSB +: HDR_NIBBLE_W];
  assign hdr_addr       = in_data[HDR_ADDR_LSB +: ADDR_WIDTH];
  assign hdr_count_m1   = in_data[HDR_COUNT_LSB +: ADDR_WIDTH];
  assign hdr_is_load    = (hdr_opcode == PWL_LOAD_OPCODE);
  assign hdr_setting_ok = setting_in_range(hdr_setting, N_SETTINGS);

  // Only payload words (offset, slope, bias) feed the checksum
  assign ck_clr = fire & (state_q == LD_IDLE) & hdr_is_load;
  assign ck_acc = fire & ((state_q == LD_OFF) | (state_q == LD_SLP) | (state_q == LD_BIAS));

  pwl_frame_checksum #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_checksum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ck_clr),
    .acc_en   (ck_acc),
    .word     (in_data),
    .cmp_word (in_data),
    .match    (ck_match)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one step per accepted word; invalid-setting frames still walk the full frame
  always_comb begin
    state_d = state_q;
    if (fire) begin
      unique case (state_q)
        LD_IDLE: if (hdr_is_load) state_d = LD_OFF;
        LD_OFF:  state_d = LD_SLP;
        LD_SLP:  state_d = (rem_q == REM_W'(1)) ? LD_BIAS : LD_OFF;
        LD_BIAS: state_d = LD_CHK;
        LD_CHK:  state_d = LD_IDLE;
        default: state_d = LD_IDLE;
      endcase
    end
  end

  // Outputs and frame context: strobes are one-cycle, data/address hold until the next write
  always_comb begin
    in_ready_d   = 1'b1;
    seg_we_d     = 1'b0;
    seg_addr_d   = seg_addr_q;
    seg_data_d   = seg_data_q;
    bias_we_d    = 1'b0;
    bias_addr_d  = bias_addr_q;
    bias_data_d  = bias_data_q;
    done_d       = 1'b0;
    busy_d       = (state_d != LD_IDLE);
    err_new      = 2'b00;
    setting_d    = setting_q;
    setting_ok_d = setting_ok_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    offset_d     = offset_q;
    bias_d       = bias_q;

    if (fire) begin
      unique case (state_q)
        LD_IDLE: begin
          if (!hdr_is_load) begin
            err_new[0] = 1'b1;
          end else begin
            err_new[0]   = ~hdr_setting_ok;
            setting_d    = hdr_setting[SETTING_WIDTH-1:0];
            setting_ok_d = hdr_setting_ok;
            addr_d       = hdr_addr;
            rem_d        = {1'b0, hdr_count_m1} + REM_W'(1);
          end
        end
        LD_OFF: begin
          offset_d = in_data[OFFSET_WIDTH-1:0];
        end
        LD_SLP: begin
          if (setting_ok_q) begin
            seg_we_d   = 1'b1;
            seg_addr_d = {setting_q, addr_q};
            seg_data_d = {offset_q, in_data[SLOPE_WIDTH-1:0]};
          end
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - REM_W'(1);
        end
        LD_BIAS: begin
          bias_d = in_data[BIAS_WIDTH-1:0];
        end
        LD_CHK: begin
          if (!ck_match) begin
            err_new[1] = 1'b1;
          end else if (setting_ok_q) begin
            bias_we_d   = 1'b1;
            done_d      = 1'b1;
            bias_addr_d = setting_q;
            bias_data_d = bias_q;
          end
        end
        default: ;
      endcase
    end

    // A new error in the same cycle as err_clr keeps its bit set
    err_d = (err_q & ~{2{err_clr}}) | err_new;
  end

  // Output and context registers; reset kills any visible strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      seg_we_q     <= 1'b0;
      seg_addr_q   <= '0;
      seg_data_q   <= '0;
      bias_we_q    <= 1'b0;
      bias_addr_q  <= '0;
      bias_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 2'b00;
      setting_q    <= '0;
      setting_ok_q <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
      offset_q     <= '0;
      bias_q       <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      seg_we_q     <= seg_we_d;
      seg_addr_q   <= seg_addr_d;
      seg_data_q   <= seg_data_d;
      bias_we_q    <= bias_we_d;
      bias_addr_q  <= bias_addr_d;
      bias_data_q  <= bias_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      setting_q    <= setting_d;
      setting_ok_q <= setting_ok_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      offset_q     <= offset_d;
      bias_q       <= bias_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign seg_we    = seg_we_q;
  assign seg_addr  = seg_addr_q;
  assign seg_data  = seg_data_q;
  assign bias_we   = bias_we_q;
  assign bias_addr = bias_addr_q;
  assign bias_data = bias_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pwl_coeff_loader.sv
// tb/tb_pwl_coeff_loader.sv - randomized self-checking bench for pwl_coeff_loader
module tb_pwl_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        seg_we;
  logic [9:0]  seg_addr;
  logic [35:0] seg_data;
  logic        bias_we;
  logic [1:0]  bias_addr;
  logic [17:0] bias_data;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  pwl_coeff_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seg_we    (seg_we),
    .seg_addr  (seg_addr),
    .seg_data  (seg_data),
    .bias_we   (bias_we),
    .bias_addr (bias_addr),
    .bias_data (bias_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    bit seg; logic [9:0] sa; logic [35:0] sd;
    bit bias; logic [1:0] ba; logic [17:0] bd;
    logic [1:0] eset; bit bchg; bit bval;
  } eff_t;
  typedef eff_t effq_t[$];
  typedef struct { int due; logic [9:0] a; logic [35:0] d; } seg_exp_t;
  typedef struct { int due; logic [1:0] a; logic [17:0] d; } bias_exp_t;
  typedef struct { int due; logic [1:0] clr; logic [1:0] set; bit bchg; bit bval; } ev_t;

  seg_exp_t  seg_q[$];
  bias_exp_t bias_q[$];
  ev_t       ev_q[$];
  logic [1:0]  exp_err = 2'b00;
  bit          exp_busy = 1'b0;
  logic [9:0]  last_sa = '0;
  logic [35:0] last_sd = '0;
  logic [1:0]  last_ba = '0;
  logic [17:0] last_bd = '0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xor_payload(input wq_t w);
    logic [31:0] x = '0;
    for (int k = 1; k < w.size() - 1; k++) x ^= w[k];
    return x;
  endfunction

  // Frame-level model: what each accepted word of the frame must cause
  task automatic model_frame(input wq_t w, output effq_t e);
    eff_t z;
    logic [3:0] op, st;
    int start, n, last;
    bit ok;
    logic [31:0] x;
    z = '{default: 0};
    e = {};
    for (int k = 0; k < w.size(); k++) e.push_back(z);
    op = w[0][31:28];
    st = w[0][27:24];
    if (op != 4'h1) begin
      e[0].eset = 2'b01;
      return;
    end
    ok = (st < 4'd4);
    start = int'(w[0][19:12]);
    n = int'(w[0][7:0]) + 1;
    e[0].eset = ok ? 2'b00 : 2'b01;
    e[0].bchg = 1'b1;
    e[0].bval = 1'b1;
    x = '0;
    for (int i = 0; i < n; i++) begin
      x ^= w[1 + 2*i] ^ w[2 + 2*i];
      if (ok) begin
        e[2 + 2*i].seg = 1'b1;
        e[2 + 2*i].sa  = {st[1:0], 8'((start + i) % 256)};
        e[2 + 2*i].sd  = {w[1 + 2*i][17:0], w[2 + 2*i][17:0]};
      end
    end
    x ^= w[2*n + 1];
    last = 2*n + 2;
    e[last].bchg = 1'b1;
    e[last].bval = 1'b0;
    if (w[last] == x) begin
      if (ok) begin
        e[last].bias = 1'b1;
        e[last].ba   = st[1:0];
        e[last].bd   = w[2*n + 1][17:0];
      end
    end else begin
      e[last].eset = 2'b10;
    end
  endtask

  task automatic build_frame(input logic [3:0] op, input logic [3:0] st, input logic [11:0] start,
                             input logic [11:0] cm1, input bit corrupt, output wq_t w);
    logic [31:0] x, r;
    w = {};
    w.push_back({op, st, start, cm1});
    if (op != 4'h1) return;
    x = '0;
    for (int i = 0; i < 2 * (int'(cm1[7:0]) + 1) + 1; i++) begin
      r = $urandom;
      w.push_back(r);
      x ^= r;
    end
    w.push_back(corrupt ? (x ^ (32'h1 << $urandom_range(0, 31))) : x);
  endtask

  task automatic send_word(input logic [31:0] w, input bit randv, input bit clr, output int acc);
    int guard = 0;
    acc = -1;
    while (acc < 0) begin
      @(negedge clk); #1;
      in_data  = w;
      in_valid = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      err_clr  = clr && in_valid && in_ready;
      if (in_valid && in_ready) acc = cyc;
      else if (guard++ > 100) begin
        check("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_frame(input wq_t w, input bit randv, input bit clr_first, input int nwords);
    effq_t e;
    int acc;
    bit c;
    model_frame(w, e);
    for (int k = 0; k < w.size(); k++) begin
      if (nwords >= 0 && k >= nwords) return;
      c = clr_first && (k == 0);
      send_word(w[k], randv, c, acc);
      if (acc < 0) return;
      if (e[k].seg)  seg_q.push_back('{acc + 1, e[k].sa, e[k].sd});
      if (e[k].bias) bias_q.push_back('{acc + 1, e[k].ba, e[k].bd});
      ev_q.push_back('{acc + 1, c ? 2'b11 : 2'b00, e[k].eset, e[k].bchg, e[k].bval});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
      err_clr  = 1'b0;
    end
  endtask

  task automatic clear_err();
    @(negedge clk); #1;
    in_valid = 1'b0;
    err_clr  = 1'b1;
    ev_q.push_back('{cyc + 1, 2'b11, 2'b00, 1'b0, 1'b0});
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
    seg_q.delete(); bias_q.delete(); ev_q.delete();
    exp_err = 2'b00; exp_busy = 1'b0;
    last_sa = '0; last_sd = '0; last_ba = '0; last_bd = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Compare process: DUT outputs against the model expectations every cycle
  initial begin
    bit exp_s, exp_b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_ctrl", 64'({in_ready, seg_we, bias_we, busy, done, err, seg_addr, bias_addr, bias_data}), 64'(0));
        check("reset_seg_data", 64'(seg_data), 64'(0));
      end else begin
        while (ev_q.size() > 0 && ev_q[0].due <= cyc) begin
          exp_err = (exp_err & ~ev_q[0].clr) | ev_q[0].set;
          if (ev_q[0].bchg) exp_busy = ev_q[0].bval;
          void'(ev_q.pop_front());
        end
        exp_s = (seg_q.size() > 0 && seg_q[0].due == cyc);
        check("seg_we", 64'(seg_we), 64'(exp_s));
        if (exp_s) begin
          last_sa = seg_q[0].a;
          last_sd = seg_q[0].d;
          void'(seg_q.pop_front());
        end
        check("seg_addr", 64'(seg_addr), 64'(last_sa));
        check("seg_data", 64'(seg_data), 64'(last_sd));
        exp_b = (bias_q.size() > 0 && bias_q[0].due == cyc);
        check("bias_we", 64'(bias_we), 64'(exp_b));
        check("done", 64'(done), 64'(exp_b));
        if (exp_b) begin
          last_ba = bias_q[0].a;
          last_bd = bias_q[0].d;
          void'(bias_q.pop_front());
        end
        check("bias_addr", 64'(bias_addr), 64'(last_ba));
        check("bias_data", 64'(bias_data), 64'(last_bd));
        check("busy", 64'(busy), 64'(exp_busy));
        check("err", 64'(err), 64'(exp_err));
        check("in_ready", 64'(in_ready), 64'(1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    wq_t w, w2;
    effq_t e;
    logic [3:0] op, st;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed two-entry frame with hand-computed values pinning the model
    w = {32'h1101_0001, 32'h100, 32'h2, 32'h200, 32'h4, 32'h55};
    w.push_back(32'h0);
    w[6] = xor_payload(w);
    check("pin_xor", 64'(w[6]), 64'(32'h353));
    model_frame(w, e);
    check("pin_seg0_addr", 64'(e[2].sa), 64'(10'h110));
    check("pin_seg0_data", 64'(e[2].sd), 64'(36'h004000002));
    check("pin_seg1_addr", 64'(e[4].sa), 64'(10'h111));
    check("pin_seg1_data", 64'(e[4].sd), 64'(36'h008000004));
    check("pin_bias", 64'({e[6].bias, e[6].ba, e[6].bd}), 64'({1'b1, 2'd1, 18'h55}));
    send_frame(w, 1'b0, 1'b0, -1);
    idle(3);

    // Same frame with checksum off by one
    w[6] = 32'h354;
    model_frame(w, e);
    check("pin_bad_chk", 64'({e[6].bias, e[6].eset}), 64'({1'b0, 2'b10}));
    send_frame(w, 1'b0, 1'b0, -1);
    idle(3);
    clear_err();

    // Bad opcode, then a valid frame
    build_frame(4'h7, 4'h1, 12'h020, 12'h0, 1'b0, w);
    send_frame(w, 1'b0, 1'b0, -1);
    build_frame(4'h1, 4'h3, 12'h040, 12'h2, 1'b0, w);
    send_frame(w, 1'b0, 1'b0, -1);
    idle(3);
    clear_err();

    // Out-of-range setting: consumed silently, next frame aligned
    build_frame(4'h1, 4'h5, 12'h080, 12'h1, 1'b0, w);
    send_frame(w, 1'b0, 1'b0, -1);
    build_frame(4'h1, 4'h0, 12'h090, 12'h1, 1'b0, w);
    send_frame(w, 1'b0, 1'b0, -1);
    idle(3);
    clear_err();

    // Address wrap, then same frame with gappy in_valid
    build_frame(4'h1, 4'h2, 12'h0FF, 12'h1, 1'b0, w);
    model_frame(w, e);
    check("pin_wrap0", 64'(e[2].sa), 64'(10'h2FF));
    check("pin_wrap1", 64'(e[4].sa), 64'(10'h200));
    send_frame(w, 1'b0, 1'b0, -1);
    idle(2);
    send_frame(w, 1'b1, 1'b0, -1);
    idle(3);

    // Reset after the first slope word, then a clean frame
    build_frame(4'h1, 4'h1, 12'h030, 12'h2, 1'b0, w);
    send_frame(w, 1'b0, 1'b0, 3);
    do_reset();
    idle(2);
    build_frame(4'h1, 4'h1, 12'h030, 12'h0, 1'b0, w2);
    send_frame(w2, 1'b1, 1'b0, -1);
    idle(3);

    // Error then err_clr coinciding with a new bad-opcode error
    build_frame(4'h9, 4'h0, 12'h0, 12'h0, 1'b0, w);
    send_frame(w, 1'b0, 1'b0, -1);
    send_frame(w, 1'b0, 1'b1, -1);
    idle(3);
    clear_err();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'h1;
      st = 4'($urandom_range(0, 5));
      build_frame(op, st, 12'($urandom), 12'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, w);
      send_frame(w, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) clear_err();
    end

    idle(5);
    check("seg_queue_empty", 64'(seg_q.size()), 64'(0));
    check("bias_queue_empty", 64'(bias_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwl_coeff_loader.md
Name: pwl_coeff_loader

Overview:
- Runtime writer for the PWL evaluator's coefficient memories; it is the producer side of the segment/bias tables that the PWL block reads.
- Accepts a framed word stream from the host/JTAG bridge over a valid/ready interface.
- Decodes each frame and issues write strobes into the segment RAM (offset, slope) and the bias RAM for one RX setting.
- Verifies a per-frame XOR checksum before committing the bias, which is the last write of a frame.

Parameters:
- N_SETTINGS, 4, number of RX settings (tables) held by the PWL.
- SETTING_WIDTH, 2, width of the setting index; must be ≤ 4.
- ADDR_WIDTH, 8, segment address bits per setting; must be ≤ 12.
- OFFSET_WIDTH, 18, segment offset bits; must be ≤ WORD_WIDTH.
- SLOPE_WIDTH, 18, segment slope bits; must be ≤ WORD_WIDTH.
- BIAS_WIDTH, 18, bias bits; must be ≤ WORD_WIDTH.
- WORD_WIDTH, 32, stream word width; fixed at 32 for the header layout.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_data, in, WORD_WIDTH: stream word.
- in_valid, in, 1: word present.
- in_ready, out, 1: loader accepts the word this cycle.
- seg_we, out, 1: segment write strobe.
- seg_addr, out, SETTING_WIDTH+ADDR_WIDTH: {setting, addr}.
- seg_data, out, OFFSET_WIDTH+SLOPE_WIDTH: {offset, slope}.
- bias_we, out, 1: bias write strobe.
- bias_addr, out, SETTING_WIDTH: setting.
- bias_data, out, BIAS_WIDTH: bias value.
- busy, out, 1: frame in progress; the PWL user must not rely on outputs while high.
- done, out, 1: one-cycle pulse when a frame commits successfully.
- err, out, 2: sticky error flags. Bit0 = bad opcode or setting; bit1 = checksum mismatch.
- err_clr, in, 1: clears err.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE
  - in_ready=0, busy=0, done=0, err=0
  - seg_we=0, bias_we=0
  - all data and address outputs = 0
- in_ready=1 in every state once out of reset. A word transfers on the clk edge where in_valid & in_ready.
- Header word layout:
  - [31:28] opcode; 4'h1 = LOAD.
  - [27:24] setting.
  - [23:12] start_addr; low ADDR_WIDTH bits used.
  - [11:0] count_m1; entries = count_m1+1, truncated to ADDR_WIDTH+1 bits, maximum 2^ADDR_WIDTH.
- States and transitions:
  - IDLE: on a header with opcode == LOAD, latch the setting, address and remaining count, zero the checksum, and go to OFF. busy rises the cycle after acceptance.
  - IDLE, opcode != LOAD: set err[0], stay in IDLE, write nothing.
  - OFF: accept one word; latch the offset from word[OFFSET_WIDTH-1:0]; go to SLP.
  - SLP: accept one word.
    - Next cycle: seg_we=1 for exactly one cycle, seg_addr={setting, addr}, seg_data={offset, slope}.
    - addr increments modulo 2^ADDR_WIDTH (wraps; no error); remaining decrements.
    - If remaining was 1, go to BIAS; otherwise go to OFF.
  - BIAS: accept one word; latch the bias; go to CHK.
  - CHK: accept one word.
    - If it equals the XOR of every payload word in the frame (excluding header and checksum), then next cycle: bias_we=1 and done=1 for one cycle, busy falls, return to IDLE.
    - Otherwise: set err[1], no bias write, no done, return to IDLE.
- Segment writes already issued in a failed frame are not rolled back.
- Invalid setting (setting ≥ N_SETTINGS): set err[0] at header acceptance. The frame is still parsed to its end so that stream alignment is kept, but all seg_we, bias_we and done are suppressed.
- Write latency: seg_we / bias_we assert exactly one cycle after the final word of that entry is accepted. Data and address outputs hold their values until the next write.
- err_clr and a new error in the same cycle: the new error wins (the bit stays set).
- in_valid may drop at any point mid-frame. The FSM waits indefinitely; there is no timeout.
- rst_n asserted mid-frame: immediate return to IDLE. A write strobe already visible is killed, and no partial bias is committed.

Decomposition:
- filter_package gains:
  - PWL_LOAD_OPCODE = 4'h1
  - header field position constants
  - a loader state enum typedef
  - widths derived from the existing FILTER_* arrays, so the top level instantiates the loader with FILTER_OFFSET_WIDTHS[k] etc.
- One sub-module, pwl_frame_checksum: a running XOR register with clear and accumulate enables, and a compare output.

Test Plan:
- Frame LOAD, setting 1, start 0x10, count_m1 1. Payload: off 0x00100, slp 0x00002, off 0x00200, slp 0x00004, bias 0x00055. Checksum = XOR of those five words.
  -> Two seg_we pulses: addr {1, 0x10} data {0x100, 0x2}, then addr {1, 0x11} data {0x200, 0x4}. Then bias_we with addr 1 and data 0x55, done pulse, err=0.
- Same frame with checksum off by 1 -> seg writes occur, no bias_we, no done, err=2'b10.
- Header opcode 4'h7 -> err=2'b01, no strobes. A following valid frame still commits normally.
- Setting 5 with N_SETTINGS=4 -> err[0] set, the full frame is consumed, zero strobes. The next frame is aligned and commits.
- start_addr 0xFF, count_m1 1, ADDR_WIDTH=8 -> seg_addr low bits 0xFF then 0x00.
- in_valid toggled randomly (50%) during a frame -> writes identical to the back-to-back case. rst_n pulsed after the first slope word -> no bias_we, busy=0, IDLE.
